// File: rtl/scatter16_pkg.sv
//==============================================================================
// scatter16_pkg : shared constants and FSM state type for the scatter16 loader
// Rev 1.0
//==============================================================================
`default_nettype none

package scatter16_pkg;
   localparam int DATA_BITWIDTH_DEF = 16;
   localparam int LANES             = 16;
   localparam int LANE_SLICE_W      = DATA_BITWIDTH_DEF;
   localparam int IDX_W             = 4;
   localparam int CNT_W             = 5;

   typedef enum logic [0:0] {
      ST_FILL = 1'b0,
      ST_HOLD = 1'b1
   } state_e;
endpackage

`default_nettype wire

// File: rtl/scatter16_lane_reg_bank.sv
//==============================================================================
// scatter16_lane_reg_bank : lane register file, one-hot write from index,
// optional synchronous clear (SCATTER16_FLUSH_EN).            Rev 1.0
//==============================================================================
`default_nettype none

module scatter16_lane_reg_bank #(
   parameter int DATA_BITWIDTH = scatter16_pkg::DATA_BITWIDTH_DEF,
   parameter int LANES         = scatter16_pkg::LANES
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           wr_en,
   input  logic [$clog2(LANES)-1:0]       wr_idx,
   input  logic [DATA_BITWIDTH-1:0]       wr_data,
`ifdef SCATTER16_FLUSH_EN
   input  logic                           clr,
`endif
   output logic [LANES*DATA_BITWIDTH-1:0] lanes
);
   import scatter16_pkg::*;

   localparam int IDX_BITS = $clog2(LANES);

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      logic [DATA_BITWIDTH-1:0] lane_q;
      logic [DATA_BITWIDTH-1:0] lane_d;

      // The write wins over the clear so lane 0 of a new bundle is kept.
      always_comb begin
         lane_d = lane_q;
`ifdef SCATTER16_FLUSH_EN
         if (clr) begin
            lane_d = '0;
         end
`endif
         if (wr_en && (wr_idx == IDX_BITS'(i))) begin
            lane_d = wr_data;
         end
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            lane_q <= '0;
         end else begin
            lane_q <= lane_d;
         end
      end

      assign lanes[i*DATA_BITWIDTH +: DATA_BITWIDTH] = lane_q;
   end
endmodule

`default_nettype wire

// File: rtl/scatter16.sv
//==============================================================================
// scatter16 : serial-to-parallel 16-lane loader with valid/ready on both sides.
// SCATTER16_FLUSH_EN enables early close on in_last.          Rev 1.0
//==============================================================================
`default_nettype none

module scatter16 #(
   parameter int DATA_BITWIDTH = scatter16_pkg::DATA_BITWIDTH_DEF,
   parameter int LANES         = scatter16_pkg::LANES
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [DATA_BITWIDTH-1:0]    in_data,
   input  logic                        in_last,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [16*DATA_BITWIDTH-1:0] out_data,
   output logic [4:0]                  out_count
);
   import scatter16_pkg::*;

   if (LANES != 16) begin : g_lanes_check
      $error("scatter16: LANES must be 16");
   end

   state_e           state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             in_acc;
   logic             out_acc;
   logic             close_bundle;

`ifdef SCATTER16_FLUSH_EN
   logic             lane_clr;
   assign close_bundle = (idx_q == IDX_W'(LANES-1)) | in_last;
   assign lane_clr     = in_acc & (idx_q == '0);
`else
   logic             unused_in_last;
   assign unused_in_last = in_last;
   assign close_bundle   = (idx_q == IDX_W'(LANES-1));
`endif

   // In HOLD idx_q is always 0, so a word accepted alongside the outgoing
   // bundle naturally lands in lane 0 with no bubble.
   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      count_d  = count_q;
      in_ready = (state_q == ST_FILL) | out_ready;
      in_acc   = in_valid & in_ready;
      out_acc  = (state_q == ST_HOLD) & out_ready;

      if (out_acc) begin
         state_d = ST_FILL;
      end
      if (in_acc) begin
         if (close_bundle) begin
            state_d = ST_HOLD;
            idx_d   = '0;
            count_d = {1'b0, idx_q} + CNT_W'(1);
         end else begin
            idx_d   = idx_q + IDX_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_FILL;
         idx_q   <= '0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         count_q <= count_d;
      end
   end

   assign out_valid = (state_q == ST_HOLD);
   assign out_count = count_q;

   scatter16_lane_reg_bank #(
      .DATA_BITWIDTH (DATA_BITWIDTH),
      .LANES         (16)
   ) u_bank (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (in_acc),
      .wr_idx  (idx_q),
      .wr_data (in_data),
`ifdef SCATTER16_FLUSH_EN
      .clr     (lane_clr),
`endif
      .lanes   (out_data)
   );
endmodule

`default_nettype wire

// File: tb/tb_scatter16.sv
//==============================================================================
// tb_scatter16 : scoreboard bench for scatter16 (honours SCATTER16_FLUSH_EN).
// Rev 1.0
//==============================================================================
`default_nettype none

module tb_scatter16;
   localparam int DW = 16;
   localparam int NL = 16;
`ifdef SCATTER16_FLUSH_EN
   localparam bit FLUSH = 1'b1;
`else
   localparam bit FLUSH = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [DW-1:0]    in_data = '0;
   logic             in_last = 1'b0;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [NL*DW-1:0] out_data;
   logic [4:0]       out_count;

   typedef struct {
      logic [NL*DW-1:0] data;
      logic [4:0]       count;
   } bundle_t;

   bundle_t       exp_q[$];
   logic [DW-1:0] mdl_lane [NL];
   int            mdl_cnt = 0;
   int            n_cmp = 0;
   int            n_mis = 0;

   always #5 clk = ~clk;

   scatter16 #(.DATA_BITWIDTH(DW), .LANES(NL)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_count (out_count)
   );

   task automatic check(input string tag, input logic [NL*DW-1:0] obs, input logic [NL*DW-1:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_mis++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      exp_q.delete();
      mdl_cnt = 0;
      for (int i = 0; i < NL; i++) mdl_lane[i] = '0;
   endtask

   task automatic model_word(input logic [DW-1:0] d, input logic l);
      bundle_t b;
      if (FLUSH && mdl_cnt == 0) begin
         for (int i = 0; i < NL; i++) mdl_lane[i] = '0;
      end
      mdl_lane[mdl_cnt] = d;
      mdl_cnt++;
      if (mdl_cnt == NL || (FLUSH && l)) begin
         for (int i = 0; i < NL; i++) b.data[i*DW +: DW] = mdl_lane[i];
         b.count = 5'(mdl_cnt);
         exp_q.push_back(b);
         mdl_cnt = 0;
      end
   endtask

   task automatic drive_cycle(input logic v, input logic [DW-1:0] d, input logic l,
                              input logic r, output logic acc);
      @(negedge clk);
      in_valid  = v;
      in_data   = d;
      in_last   = l;
      out_ready = r;
      #1;
      check("out_valid", out_valid, exp_q.size() != 0);
      check("in_ready", in_ready, (exp_q.size() == 0) ? 1'b1 : r);
      if (out_valid && exp_q.size() != 0) begin
         check("out_data", out_data, exp_q[0].data);
         check("out_count", out_count, exp_q[0].count);
         if (out_ready) void'(exp_q.pop_front());
      end
      acc = v & in_ready;
      if (acc) model_word(d, l);
   endtask

   task automatic send_word(input logic [DW-1:0] d, input logic l, input logic r, output int tries);
      logic acc;
      tries = 0;
      acc   = 1'b0;
      while (!acc && tries < 64) begin
         drive_cycle(1'b1, d, l, r, acc);
         tries++;
      end
      if (!acc) check("send_timeout", 1'b0, 1'b1);
   endtask

   task automatic idle(input int n, input logic r);
      logic acc;
      for (int i = 0; i < n; i++) drive_cycle(1'b0, '0, 1'b0, r, acc);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_last   = 1'b0;
      out_ready = 1'b0;
      #1;
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_out_data", out_data, '0);
      check("rst_out_count", out_count, 5'd0);
      check("rst_in_ready", in_ready, 1'b1);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      int   tries;
      int   sent;
      int   budget;
      logic acc;
      logic v, r;

      model_reset();
      do_reset();

      // single bundle, consumer always ready
      for (int w = 1; w <= 16; w++) send_word(DW'(w), 1'b0, 1'b1, tries);
      idle(3, 1'b1);

      // consumer stalls in HOLD; word 17 must wait
      for (int w = 1; w <= 16; w++) send_word(DW'(w), 1'b0, 1'b0, tries);
      for (int k = 0; k < 5; k++) begin
         drive_cycle(1'b1, DW'(17), 1'b0, 1'b0, acc);
         check("hold_no_accept", acc, 1'b0);
      end
      send_word(DW'(17), 1'b0, 1'b1, tries);
      check("accept_on_ready", tries, 1);
      for (int w = 18; w <= 32; w++) send_word(DW'(w), 1'b0, 1'b1, tries);
      idle(2, 1'b1);

      // back-to-back 48 words, no bubbles
      for (int w = 0; w < 48; w++) begin
         send_word(DW'(16'h1000 + w), 1'b0, 1'b1, tries);
         check("b2b_no_bubble", tries, 1);
      end
      idle(2, 1'b1);
      check("b2b_drained", exp_q.size(), 0);

      // random gaps on both sides
      sent   = 0;
      budget = 0;
      while (sent < 1008 && budget < 20000) begin
         v = ($urandom_range(0, 3) != 0);
         r = ($urandom_range(0, 2) != 0);
         drive_cycle(v, DW'(16'h4000 + sent), 1'b0, r, acc);
         if (acc) sent++;
         budget++;
      end
      check("rand_words_sent", sent, 1008);
      budget = 0;
      while (exp_q.size() != 0 && budget < 100) begin
         idle(1, 1'b1);
         budget++;
      end
      check("rand_drained", exp_q.size(), 0);

      // short bundle closed by in_last
      send_word(DW'(7), 1'b0, 1'b1, tries);
      send_word(DW'(8), 1'b0, 1'b1, tries);
      send_word(DW'(9), 1'b1, 1'b1, tries);
      idle(4, 1'b1);
      check("flush_drained", exp_q.size(), 0);

      // reset mid-fill discards the partial bundle
      do_reset();
      for (int w = 0; w < 10; w++) send_word(DW'(16'hA000 + w), 1'b0, 1'b1, tries);
      do_reset();
      for (int w = 0; w < 16; w++) send_word(DW'(16'hB000 + w), 1'b0, 1'b1, tries);
      idle(3, 1'b1);
      check("final_drained", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end
endmodule

`default_nettype wire
